// File: rtl/byte_serial_addsub.sv
// byte_serial_addsub: 32-bit add/subtract computed one byte per cycle,
// least significant byte first, on a single reused 8-bit ripple slice.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready request handshake (accepted only in IDLE)
//   i_a, i_b                32-bit operands
//   i_sub                   1: A-B, 0: A+B+i_ci (forced to add if ALLOW_SUB=0)
//   i_ci                    carry-in for add, ignored for subtract
//   o_rsp_valid/i_rsp_ready response handshake (valid only in DONE)
//   o_s, o_co, o_ovf, o_zero result, carry out of bit 31, signed overflow, zero
//   o_busy                  high whenever the FSM is not IDLE

// full_adder_8bit: 8-bit ripple-carry adder slice.
// Ports: i_a, i_b (8-bit addends), i_ci (carry-in), o_s (sum), o_co (carry-out).
module full_adder_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  output logic [7:0] o_s,
  output logic       o_co
);

  logic [8:0] w_c;

  always_comb begin
    o_s    = '0;
    w_c    = '0;
    w_c[0] = i_ci;
    for (int unsigned i = 0; i < 8; i++) begin
      o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_co = w_c[8];

endmodule

module byte_serial_addsub #(
  parameter int ALLOW_SUB = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  input  logic        i_ci,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_s,
  output logic        o_co,
  output logic        o_ovf,
  output logic        o_zero,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;      // already inverted for subtract
  logic        r_c;      // running carry between byte slices
  logic [31:0] r_s;
  logic        r_co;
  logic        r_ovf;
  logic        r_zero;

  logic        w_sub;
  logic [4:0]  w_bit;
  logic [7:0]  w_a_byte;
  logic [7:0]  w_b_byte;
  logic [7:0]  w_sum;
  logic        w_co;

  assign w_sub    = (ALLOW_SUB != 0) && i_sub;
  assign w_bit    = {r_cnt, 3'b000};
  assign w_a_byte = r_a[w_bit +: 8];
  assign w_b_byte = r_b[w_bit +: 8];

  full_adder_8bit u_slice (
    .i_a  (w_a_byte),
    .i_b  (w_b_byte),
    .i_ci (r_c),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_a     <= i_a;
            r_b     <= w_sub ? ~i_b : i_b;
            r_c     <= w_sub ? 1'b1 : i_ci;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_s[w_bit +: 8] <= w_sum;
          r_c             <= w_co;
          r_cnt           <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            // Top byte: flags use the slice output directly since r_s[31:24]
            // is only being written on this same edge.
            r_state <= S_DONE;
            r_co    <= w_co;
            r_ovf   <= (r_a[31] == r_b[31]) && (w_sum[7] != r_a[31]);
            r_zero  <= ({w_sum, r_s[23:0]} == '0);
          end
        end
        S_DONE: begin
          if (i_rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_s         = r_s;
  assign o_co        = r_co;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;

endmodule

// File: tb/tb_byte_serial_addsub.sv
module tb_byte_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        ci;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] s;
  logic        co;
  logic        ovf;
  logic        zero;
  logic        busy;

  int errors = 0;
  int checks = 0;

  byte_serial_addsub #(.ALLOW_SUB(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_a         (a),
    .i_b         (b),
    .i_sub       (sub),
    .i_ci        (ci),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_s         (s),
    .o_co        (co),
    .o_ovf       (ovf),
    .o_zero      (zero),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        ci;
    logic [31:0] exp_s;
    logic        exp_co;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Accept one operation, scramble the inputs right after acceptance, and
  // return the number of edges until o_rsp_valid (0 if it never came).
  task automatic start_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic vsub, input logic vci, output int lat);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    a = va; b = vb; sub = vsub; ci = vci; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = ~va; b = va ^ 32'h5A5A_A5A5; sub = ~vsub; ci = ~vci;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_op();
    logic [31:0] held;
    @(negedge clk);
    held = s;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    check("req_ready_back", {31'b0, req_ready}, 32'd1);
    check("s_kept_after_hs", s, held);
  endtask

  initial begin
    int lat;
    logic [31:0] held_s;
    logic [2:0]  held_f;
    bit          saw_valid;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; ci = 1'b0;
    #12;
    check("rst_s", s, 32'd0);
    check("rst_flags", {29'b0, co, ovf, zero}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;           // must not be taken while in reset
    @(posedge clk);
    #1;
    check("rst_no_accept", {31'b0, busy}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd4);
      check($sformatf("v%0d_s", i), s, vecs[i].exp_s);
      check($sformatf("v%0d_co", i), {31'b0, co}, {31'b0, vecs[i].exp_co});
      check($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
      check($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].exp_zero});
      finish_op();
    end

    // Back-pressure: DONE held 10 cycles with a competing request present.
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 32'd4);
    held_s = s;
    held_f = {co, ovf, zero};
    req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_s_stable", s, held_s);
      check("bp_flags_stable", {29'b0, co, ovf, zero}, {29'b0, held_f});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_release_idle", {31'b0, rsp_valid}, 32'd0);
    check("bp_no_same_cycle_accept", {31'b0, busy}, 32'd0);
    check("bp_req_ready", {31'b0, req_ready}, 32'd1);
    check("bp_s_kept", s, 32'h0000_0100);
    req_valid = 1'b0;

    // Reset after two bytes have been written.
    @(negedge clk);
    a = 32'h0101_0101; b = 32'h0101_0101; sub = 1'b0; ci = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_calc_partial", s, 32'h0000_0202);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_s", s, 32'd0);
    check("midrst_flags", {29'b0, co, ovf, zero}, 32'd0);
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) saw_valid = 1'b1;
    end
    check("midrst_no_response", {31'b0, saw_valid}, 32'd0);

    // Block still usable after the aborted operation.
    start_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, lat);
    check("post_rst_latency", lat, 32'd4);
    check("post_rst_s", s, 32'h7FFF_FFFF);
    finish_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/byte_serial_addsub.md
BYTE_SERIAL_ADDSUB -- requirements
Module: byte_serial_addsub

Interface
REQ-001 SHALL have parameter ALLOW_SUB, default 1, meaning i_sub is honoured; when ALLOW_SUB = 0, i_sub is treated as 0.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port i_req_valid, input, 1, meaning the requester presents an operation.
REQ-005 SHALL have port o_req_ready, output, 1, meaning the block can accept an operation.
REQ-006 SHALL have ports i_a and i_b, input, 32, holding operands A and B.
REQ-007 SHALL have port i_sub, input, 1, selecting subtract (1: A-B) or add (0: A+B+i_ci).
REQ-008 SHALL have port i_ci, input, 1, the carry-in for add; it is ignored for subtract.
REQ-009 SHALL have port o_rsp_valid, output, 1, meaning the result is available.
REQ-010 SHALL have port i_rsp_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have ports o_s (output, 32, sum/difference) and o_co (output, 1, carry out of bit 31).
REQ-012 SHALL have ports o_ovf (output, 1, signed overflow) and o_zero (output, 1, o_s == 0).
REQ-013 SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL compute the result with one 8-bit ripple adder slice, reused over 4 cycles, LSB byte first; the slice SHALL be the existing full_adder_8bit.
REQ-015 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-016 SHALL set o_req_ready = 1 only in IDLE; a request is accepted on a rising edge where i_req_valid & o_req_ready.
REQ-017 SHALL, on acceptance, capture the operands, op and carry-in, clear the byte counter to 0 and enter CALC.
- Captured B = i_sub ? ~i_b : i_b.
- Captured carry-in = i_sub ? 1 : i_ci.
REQ-018 SHALL, in CALC, process byte k = counter:
- Slice inputs: A[8k+7:8k], B'[8k+7:8k], and the running carry.
- On each edge, write the slice sum into o_s[8k+7:8k], store the slice carry-out and increment the counter.
REQ-019 SHALL, on the edge that processes byte 3 (counter wrap 3 -> 0), enter DONE and latch o_co, o_ovf and o_zero.
- o_co = final slice carry-out.
- o_ovf = (A[31] == B'[31]) & (o_s[31] != A[31]).
- o_zero = (full 32-bit result == 0).
REQ-020 SHALL give a latency of exactly 4 cycles: o_rsp_valid rises on the 4th rising edge after the accepting edge.
REQ-021 SHALL assert o_rsp_valid = 1 only in DONE, holding o_s, o_co, o_ovf and o_zero stable until the handshake.
REQ-022 SHALL, in DONE with i_rsp_ready = 1 at an edge, return to IDLE.
- o_rsp_valid deasserts and o_req_ready asserts on that edge.
- A new request is not accepted in that same cycle.
- Results stay at their last values until the next acceptance.
REQ-023 SHALL ignore i_a, i_b, i_sub, i_ci and i_req_valid in CALC and DONE.
REQ-024 SHALL hold in DONE indefinitely while i_rsp_ready = 0 (back-pressure).
REQ-025 SHALL give o_co the raw carry for subtract (1 = no borrow, A >= B unsigned).
REQ-026 SHALL ignore i_rsp_ready outside DONE.

Reset
REQ-027 SHALL, on i_rst_n = 0 at any time including mid-CALC, immediately do the following:
- Force the FSM to IDLE and the counter to 0.
- Force o_s = 0, o_co = 0, o_ovf = 0, o_zero = 0.
- Force o_rsp_valid = 0, o_busy = 0.
- Drive o_req_ready = 1; a request is not accepted while i_rst_n = 0.
REQ-028 SHALL discard any operation in progress at reset, producing no response for it.

Verification
REQ-029 SHALL be checked with these directed scenarios:
- Add: A=0x0000_00FF, B=0x0000_0001, ci=0 -> after 4 cycles o_s=0x0000_0100, co=0, ovf=0, zero=0.
- Carry chain: A=0xFFFF_FFFF, B=0x0000_0000, ci=1 -> o_s=0, co=1, zero=1, ovf=0.
- Sub overflow: A=0x8000_0000, B=0x0000_0001, sub=1 -> o_s=0x7FFF_FFFF, co=1, ovf=1.
- Back-pressure: hold i_rsp_ready=0 for 10 cycles in DONE -> outputs stable, o_req_ready=0, then release -> IDLE next edge.
- Operand change mid-CALC: i_a toggled after acceptance -> result reflects the captured values.
- Reset after 2 bytes are processed -> all outputs 0 and o_req_ready=1 immediately; no o_rsp_valid follows.
